beta_mc_ctrl: RTL and testbench

- Multi-cycle control unit for the 32-bit RISC datapath.
- Sequences fetch/decode/execute/memory/writeback for each instruction.
- Drives the ALU B-operand select (bsel: 0 = rd2, 1 = sign-extended const[15:0]), plus ALU function, register-file write, PC update and memory strobes.
- Sits between the instruction register and the datapath muxes. One instruction in flight; no pipelining.

---
 rtl/beta_mc_ctrl_pkg.sv | 47 ++++
 rtl/beta_op_decode.sv | 38 +++
 rtl/beta_mc_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_beta_mc_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/beta_mc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : beta_mc_ctrl_pkg
// Brief    : Shared constants for the multi-cycle Beta control unit: opcodes,
//            FSM state encodings, pcsel / wdsel codes and the ALU ADD code.
// Revision : 1.0 - initial release
// ============================================================================
package beta_mc_ctrl_pkg;

    // Opcodes of the non-ALU instructions (instr[31:26])
    localparam logic [5:0] c_op_ld  = 6'h18;
    localparam logic [5:0] c_op_st  = 6'h19;
    localparam logic [5:0] c_op_jmp = 6'h1B;
    localparam logic [5:0] c_op_beq = 6'h1C;
    localparam logic [5:0] c_op_bne = 6'h1D;

    // Two top opcode bits select the ALU classes: 10 = OP, 11 = OPC
    localparam logic [1:0] c_cls_op  = 2'b10;
    localparam logic [1:0] c_cls_opc = 2'b11;

    // FSM state encodings
    localparam int         c_state_w   = 3;
    localparam logic [2:0] c_st_rst    = 3'd0;
    localparam logic [2:0] c_st_fetch  = 3'd1;
    localparam logic [2:0] c_st_decode = 3'd2;
    localparam logic [2:0] c_st_exec   = 3'd3;
    localparam logic [2:0] c_st_mem    = 3'd4;
    localparam logic [2:0] c_st_wb     = 3'd5;
    localparam logic [2:0] c_st_trap   = 3'd6;

    // PC source select codes
    localparam logic [2:0] c_pcsel_pc4   = 3'd0;
    localparam logic [2:0] c_pcsel_br    = 3'd1;
    localparam logic [2:0] c_pcsel_jmp   = 3'd2;
    localparam logic [2:0] c_pcsel_illop = 3'd3;
    localparam logic [2:0] c_pcsel_rst   = 3'd4;

    // Register-file writeback source codes
    localparam logic [1:0] c_wdsel_pc4 = 2'd0;
    localparam logic [1:0] c_wdsel_alu = 2'd1;
    localparam logic [1:0] c_wdsel_mem = 2'd2;

    // ALU function used for LD/ST address generation
    localparam logic [5:0] c_alu_add = 6'h00;

endpackage
`default_nettype wire

// File: rtl/beta_op_decode.sv
`default_nettype none
// ============================================================================
// Module   : beta_op_decode
// Brief    : Pure combinational classification of the latched opcode into
//            instruction classes plus an overall legality flag.
// Revision : 1.0 - initial release
// ============================================================================
module beta_op_decode
    import beta_mc_ctrl_pkg::*;
#(
    parameter int OPW = 6
) (
    input  logic [OPW-1:0] op,
    output logic           cls_op,
    output logic           cls_opc,
    output logic           is_ld,
    output logic           is_st,
    output logic           is_jmp,
    output logic           is_beq,
    output logic           is_bne,
    output logic           legal
);

    // ALU classes are identified by the two most significant opcode bits
    assign cls_op  = (op[OPW-1 -: 2] == c_cls_op);
    assign cls_opc = (op[OPW-1 -: 2] == c_cls_opc);

    assign is_ld  = (op == OPW'(c_op_ld));
    assign is_st  = (op == OPW'(c_op_st));
    assign is_jmp = (op == OPW'(c_op_jmp));
    assign is_beq = (op == OPW'(c_op_beq));
    assign is_bne = (op == OPW'(c_op_bne));

    // Everything outside the listed classes traps
    assign legal = cls_op | cls_opc | is_ld | is_st | is_jmp | is_beq | is_bne;

endmodule
`default_nettype wire

// File: rtl/beta_mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : beta_mc_ctrl
// Brief    : Multi-cycle control FSM for the 32-bit Beta datapath. Sequences
//            fetch / decode / execute / memory / writeback, one instruction
//            in flight, outputs decoded from state and the latched opcode.
// Revision : 1.0 - initial release
// ============================================================================
module beta_mc_ctrl
    import beta_mc_ctrl_pkg::*;
#(
    parameter int         OPW          = 6,
    parameter int         FNW          = 6,
    parameter logic [2:0] RESET_PC_SEL = c_pcsel_rst
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [31:0]    instr,
    input  logic           imem_ack,
    input  logic           dmem_ack,
    input  logic           z,
    output logic           imem_req,
    output logic           ir_ld,
    output logic           pc_ld,
    output logic [2:0]     pcsel,
    output logic           bsel,
    output logic           ra2sel,
    output logic [FNW-1:0] alufn,
    output logic [1:0]     wdsel,
    output logic           wasel,
    output logic           werf,
    output logic           mem_rd,
    output logic           mem_wr,
    output logic           illegal
);

    logic [c_state_w-1:0] r_state;
    logic [c_state_w-1:0] w_next;
    logic [OPW-1:0]       r_op_q;

    logic w_cls_op, w_cls_opc, w_is_ld, w_is_st;
    logic w_is_jmp, w_is_beq, w_is_bne, w_legal;
    logic w_br_taken;

    // Only the opcode field is consumed here; the rest belongs to the datapath
    logic w_unused_instr;
    assign w_unused_instr = ^instr[31-OPW:0];

    beta_op_decode #(
        .OPW (OPW)
    ) u_op_decode (
        .op      (r_op_q),
        .cls_op  (w_cls_op),
        .cls_opc (w_cls_opc),
        .is_ld   (w_is_ld),
        .is_st   (w_is_st),
        .is_jmp  (w_is_jmp),
        .is_beq  (w_is_beq),
        .is_bne  (w_is_bne),
        .legal   (w_legal)
    );

    assign w_br_taken = (w_is_beq & z) | (w_is_bne & ~z);

    // State register; reset wins over any pending handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_rst;
        end else begin
            r_state <= w_next;
        end
    end

    // Opcode is captured on the same edge the instruction register loads
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op_q <= '0;
        end else if (ir_ld) begin
            r_op_q <= instr[31 -: OPW];
        end
    end

    // Next-state and output decode from state plus latched opcode
    always_comb begin
        w_next   = r_state;
        imem_req = 1'b0;
        ir_ld    = 1'b0;
        pc_ld    = 1'b0;
        pcsel    = c_pcsel_pc4;
        bsel     = 1'b0;
        ra2sel   = 1'b0;
        alufn    = '0;
        wdsel    = c_wdsel_pc4;
        wasel    = 1'b0;
        werf     = 1'b0;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        illegal  = 1'b0;

        case (r_state)
            c_st_rst: begin
                pc_ld  = 1'b1;
                pcsel  = RESET_PC_SEL;
                w_next = c_st_fetch;
            end

            c_st_fetch: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_ld  = 1'b1;
                    w_next = c_st_decode;
                end
            end

            c_st_decode: begin
                w_next = w_legal ? c_st_exec : c_st_trap;
            end

            c_st_exec: begin
                if (w_cls_op || w_cls_opc) begin
                    bsel   = w_cls_opc;
                    alufn  = FNW'(r_op_q[3:0]);
                    wdsel  = c_wdsel_alu;
                    werf   = 1'b1;
                    pc_ld  = 1'b1;
                    pcsel  = c_pcsel_pc4;
                    w_next = c_st_fetch;
                end else if (w_is_ld || w_is_st) begin
                    bsel   = 1'b1;
                    alufn  = FNW'(c_alu_add);
                    ra2sel = w_is_st;
                    w_next = c_st_mem;
                end else if (w_is_jmp) begin
                    wdsel  = c_wdsel_pc4;
                    werf   = 1'b1;
                    pc_ld  = 1'b1;
                    pcsel  = c_pcsel_jmp;
                    w_next = c_st_fetch;
                end else begin
                    // Remaining legal classes are BEQ / BNE
                    wdsel  = c_wdsel_pc4;
                    werf   = 1'b1;
                    pc_ld  = 1'b1;
                    pcsel  = w_br_taken ? c_pcsel_br : c_pcsel_pc4;
                    w_next = c_st_fetch;
                end
            end

            c_st_mem: begin
                // Address operands stay stable for the whole access
                bsel   = 1'b1;
                alufn  = FNW'(c_alu_add);
                ra2sel = w_is_st;
                mem_rd = w_is_ld;
                mem_wr = w_is_st;
                if (dmem_ack) begin
                    if (w_is_ld) begin
                        w_next = c_st_wb;
                    end else begin
                        pc_ld  = 1'b1;
                        pcsel  = c_pcsel_pc4;
                        w_next = c_st_fetch;
                    end
                end
            end

            c_st_wb: begin
                wdsel  = c_wdsel_mem;
                werf   = 1'b1;
                pc_ld  = 1'b1;
                pcsel  = c_pcsel_pc4;
                w_next = c_st_fetch;
            end

            c_st_trap: begin
                illegal = 1'b1;
                pcsel   = c_pcsel_illop;
                pc_ld   = 1'b1;
                wasel   = 1'b1;
                wdsel   = c_wdsel_pc4;
                werf    = 1'b1;
                w_next  = c_st_fetch;
            end

            default: begin
                w_next = c_st_rst;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_beta_mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_beta_mc_ctrl
// Brief    : Self-checking bench for beta_mc_ctrl: table of instructions with
//            hand-computed expectations plus directed reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_beta_mc_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr = 32'h0;
    logic        imem_ack = 1'b0;
    logic        dmem_ack = 1'b0;
    logic        z = 1'b0;

    logic        imem_req, ir_ld, pc_ld, bsel, ra2sel, wasel, werf;
    logic        mem_rd, mem_wr, illegal;
    logic [2:0]  pcsel;
    logic [5:0]  alufn;
    logic [1:0]  wdsel;

    beta_mc_ctrl #(
        .OPW          (6),
        .FNW          (6),
        .RESET_PC_SEL (3'd4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .instr    (instr),
        .imem_ack (imem_ack),
        .dmem_ack (dmem_ack),
        .z        (z),
        .imem_req (imem_req),
        .ir_ld    (ir_ld),
        .pc_ld    (pc_ld),
        .pcsel    (pcsel),
        .bsel     (bsel),
        .ra2sel   (ra2sel),
        .alufn    (alufn),
        .wdsel    (wdsel),
        .wasel    (wasel),
        .werf     (werf),
        .mem_rd   (mem_rd),
        .mem_wr   (mem_wr),
        .illegal  (illegal)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, got, exp);
        end
    endtask

    typedef struct {
        logic [5:0] op;
        logic       zin;
        int         dwait;
        int         lat;
        logic       bsel;
        logic [5:0] alufn;
        logic       ra2sel;
        int         werf_n;
        logic [1:0] wdsel;
        logic       wasel;
        logic [2:0] pcsel;
        int         ill_n;
        int         rd_n;
        int         wr_n;
    } vec_t;

    function automatic vec_t mk(input logic [5:0] op, input logic zin, input int dwait,
                                input int lat, input logic b, input logic [5:0] fn,
                                input logic ra2, input int wn, input logic [1:0] wd,
                                input logic wa, input logic [2:0] ps, input int il,
                                input int rn, input int wrn);
        vec_t v;
        v.op = op; v.zin = zin; v.dwait = dwait; v.lat = lat; v.bsel = b;
        v.alufn = fn; v.ra2sel = ra2; v.werf_n = wn; v.wdsel = wd; v.wasel = wa;
        v.pcsel = ps; v.ill_n = il; v.rd_n = rn; v.wr_n = wrn;
        return v;
    endfunction

    // Observations of one instruction, filled by run_instr
    int         obs_start, obs_lat, obs_irld_n, obs_pcld_n, obs_werf_n;
    int         obs_ill_n, obs_rd_n, obs_wr_n, obs_membad, obs_conflict;
    logic       obs_bsel, obs_ra2sel, obs_wasel;
    logic [5:0] obs_alufn;
    logic [1:0] obs_wdsel;
    logic [2:0] obs_pcsel;

    // Runs one instruction starting in FETCH; cycle 0 is the fetch cycle and
    // obs_lat is the cycle index at which the next fetch request appears.
    task automatic run_instr(input logic [5:0] op, input logic zin, input int dwait);
        int  memcnt;
        bit  done;
        memcnt = 0; done = 0;
        obs_start = 0; obs_lat = -1; obs_irld_n = 0; obs_pcld_n = 0; obs_werf_n = 0;
        obs_ill_n = 0; obs_rd_n = 0; obs_wr_n = 0; obs_membad = 0; obs_conflict = 0;
        obs_bsel = 1'bx; obs_ra2sel = 1'bx; obs_wasel = 1'bx;
        obs_alufn = 'x; obs_wdsel = 'x; obs_pcsel = 'x;
        z = zin;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            imem_ack = 1'b0;
            dmem_ack = 1'b0;
            if (k == 0) begin
                instr     = {op, 26'h0};
                imem_ack  = imem_req;
                obs_start = int'(imem_req);
            end else begin
                // Illegal garbage on the bus proves the opcode was latched
                instr = 32'h1400_0000;
                if (imem_req) begin
                    obs_lat = k;
                    done    = 1;
                end
            end
            if (mem_rd || mem_wr) begin
                dmem_ack = (memcnt == dwait);
                memcnt++;
            end
            #1;
            if (!done) begin
                if (ir_ld) obs_irld_n++;
                if (pc_ld) begin
                    obs_pcld_n++;
                    obs_pcsel = pcsel;
                end
                if (werf) begin
                    obs_werf_n++;
                    obs_wdsel = wdsel;
                    obs_wasel = wasel;
                end
                if ((werf && mem_wr) || (mem_rd && mem_wr)) obs_conflict++;
                if (mem_rd) obs_rd_n++;
                if (mem_wr) obs_wr_n++;
                if (illegal) obs_ill_n++;
                if ((mem_rd || mem_wr) && (bsel !== 1'b1 || alufn !== 6'h00)) obs_membad++;
                if (k == 2) begin
                    obs_bsel   = bsel;
                    obs_alufn  = alufn;
                    obs_ra2sel = ra2sel;
                end
            end
        end
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
    endtask

    vec_t vecs[16];

    initial begin
        // op,  z, dw, lat, bsel, alufn, ra2, werf, wdsel, wasel, pcsel, ill, rd, wr
        vecs[0]  = mk(6'h30, 0, 0, 3, 1, 6'd0,  0, 1, 2'd1, 0, 3'd0, 0, 0, 0); // ADDC
        vecs[1]  = mk(6'h20, 0, 0, 3, 0, 6'd0,  0, 1, 2'd1, 0, 3'd0, 0, 0, 0); // ADD
        vecs[2]  = mk(6'h21, 0, 0, 3, 0, 6'd1,  0, 1, 2'd1, 0, 3'd0, 0, 0, 0); // SUB
        vecs[3]  = mk(6'h3A, 1, 0, 3, 1, 6'd10, 0, 1, 2'd1, 0, 3'd0, 0, 0, 0); // OPC fn 0xA
        vecs[4]  = mk(6'h2F, 0, 0, 3, 0, 6'd15, 0, 1, 2'd1, 0, 3'd0, 0, 0, 0); // OP fn 0xF
        vecs[5]  = mk(6'h18, 0, 3, 8, 1, 6'd0,  0, 1, 2'd2, 0, 3'd0, 0, 4, 0); // LD, ack late
        vecs[6]  = mk(6'h18, 1, 0, 5, 1, 6'd0,  0, 1, 2'd2, 0, 3'd0, 0, 1, 0); // LD, ack now
        vecs[7]  = mk(6'h19, 0, 2, 6, 1, 6'd0,  1, 0, 2'd0, 0, 3'd0, 0, 0, 3); // ST
        vecs[8]  = mk(6'h1B, 0, 0, 3, 0, 6'd0,  0, 1, 2'd0, 0, 3'd2, 0, 0, 0); // JMP
        vecs[9]  = mk(6'h1C, 1, 0, 3, 0, 6'd0,  0, 1, 2'd0, 0, 3'd1, 0, 0, 0); // BEQ taken
        vecs[10] = mk(6'h1C, 0, 0, 3, 0, 6'd0,  0, 1, 2'd0, 0, 3'd0, 0, 0, 0); // BEQ not
        vecs[11] = mk(6'h1D, 0, 0, 3, 0, 6'd0,  0, 1, 2'd0, 0, 3'd1, 0, 0, 0); // BNE taken
        vecs[12] = mk(6'h1D, 1, 0, 3, 0, 6'd0,  0, 1, 2'd0, 0, 3'd0, 0, 0, 0); // BNE not
        vecs[13] = mk(6'h05, 0, 0, 3, 0, 6'd0,  0, 1, 2'd0, 1, 3'd3, 1, 0, 0); // illegal
        vecs[14] = mk(6'h1A, 0, 0, 3, 0, 6'd0,  0, 1, 2'd0, 1, 3'd3, 1, 0, 0); // illegal gap
        vecs[15] = mk(6'h1F, 1, 0, 3, 0, 6'd0,  0, 1, 2'd0, 1, 3'd3, 1, 0, 0); // illegal

        // Reset held: no fetch, no writes, no memory strobes
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_imem_req", 0, imem_req, 0);
        chk("rst_werf", 0, werf, 0);
        chk("rst_mem", 0, {mem_rd, mem_wr}, 0);

        // First cycle after rst falls: reset vector load
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_pc_ld", 0, pc_ld, 1);
        chk("post_rst_pcsel", 0, pcsel, 4);
        chk("post_rst_imem_req", 0, imem_req, 0);
        chk("post_rst_werf", 0, werf, 0);

        for (int i = 0; i < 16; i++) begin
            run_instr(vecs[i].op, vecs[i].zin, vecs[i].dwait);
            chk("fetch_start", i, obs_start, 1);
            chk("latency", i, obs_lat, vecs[i].lat);
            chk("ir_ld_count", i, obs_irld_n, 1);
            chk("exec_bsel", i, obs_bsel, vecs[i].bsel);
            chk("exec_alufn", i, obs_alufn, vecs[i].alufn);
            chk("exec_ra2sel", i, obs_ra2sel, vecs[i].ra2sel);
            chk("pc_ld_count", i, obs_pcld_n, 1);
            chk("pcsel", i, obs_pcsel, vecs[i].pcsel);
            chk("werf_count", i, obs_werf_n, vecs[i].werf_n);
            if (vecs[i].werf_n != 0) begin
                chk("wdsel", i, obs_wdsel, vecs[i].wdsel);
                chk("wasel", i, obs_wasel, vecs[i].wasel);
            end
            chk("illegal_count", i, obs_ill_n, vecs[i].ill_n);
            chk("mem_rd_cycles", i, obs_rd_n, vecs[i].rd_n);
            chk("mem_wr_cycles", i, obs_wr_n, vecs[i].wr_n);
            chk("mem_operand_hold", i, obs_membad, 0);
            chk("strobe_conflict", i, obs_conflict, 0);
        end

        // Reset in the middle of an LD memory wait, late ack ignored
        z = 1'b0;
        @(negedge clk);
        chk("seq_fetch", 100, imem_req, 1);
        instr    = {6'h18, 26'h0};
        imem_ack = 1'b1;
        @(negedge clk);             // DECODE
        imem_ack = 1'b1;            // ack outside FETCH must be ignored
        instr    = 32'h1400_0000;
        #1;
        chk("seq_decode_quiet", 101, {imem_req, ir_ld, pc_ld}, 0);
        @(negedge clk);             // EXEC
        imem_ack = 1'b0;
        @(negedge clk);             // MEM
        #1;
        chk("seq_mem_rd", 102, mem_rd, 1);
        rst = 1'b1;
        @(negedge clk);             // RST, reset still held
        dmem_ack = 1'b1;            // late ack
        #1;
        chk("seq_rst_no_mem", 103, {mem_rd, mem_wr}, 0);
        chk("seq_rst_no_werf", 103, werf, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("seq_rst_pc_ld", 104, pc_ld, 1);
        chk("seq_rst_pcsel", 104, pcsel, 4);
        chk("seq_rst_no_mem2", 104, {mem_rd, mem_wr}, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            chk("seq_idle_fetch", 105 + k, imem_req, 1);
            chk("seq_idle_quiet", 105 + k, {mem_rd, mem_wr, werf, pc_ld, ir_ld}, 0);
        end
        dmem_ack = 1'b0;

        // Normal operation resumes after the interrupted access
        run_instr(6'h20, 1'b0, 0);
        chk("resume_latency", 110, obs_lat, 3);
        chk("resume_werf", 110, obs_werf_n, 1);
        chk("resume_wdsel", 110, obs_wdsel, 1);
        chk("resume_pc_ld", 110, obs_pcld_n, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute guard against a stuck run
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
